// File: rtl/limb_pkg.sv
// Shared types and helpers for the Limb core's call/return stack.
// No logic of its own; provides the op encoding and a count max helper.
// Contents: LIMB_PC_W, stack_op_e ({push, pop} encoding), max_cnt().
package limb_pkg;

  localparam int LIMB_PC_W = 8;

  // Encoded directly as {push, pop} so the op can be cast from the two strobes.
  typedef enum logic [1:0] {
    STK_NONE    = 2'b00,
    STK_POP     = 2'b01,
    STK_PUSH    = 2'b10,
    STK_REPLACE = 2'b11
  } stack_op_e;

  // 9 bits covers counts up to the largest legal depth (256).
  function automatic logic [8:0] max_cnt(input logic [8:0] a, input logic [8:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/call_stack_if.sv
// Handshake/status bundle between the PC logic and the call stack.
// Combinational wires only; no latency of its own.
// No backpressure: push/pop are single-cycle strobes, errors are reported as flags.
// master: drives push, pop, data_in, clear_err; slave: drives top and status.
interface call_stack_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              push;
  logic              pop;
  logic [DATA_W-1:0] data_in;
  logic              clear_err;
  logic [DATA_W-1:0] top;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  high_water;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, data_in, clear_err,
    input  top, empty, full, count, high_water, overflow, underflow
  );

  modport slave (
    input  push, pop, data_in, clear_err,
    output top, empty, full, count, high_water, overflow, underflow
  );
endinterface

// File: rtl/stack_mem.sv
// DEPTH x DATA_W storage for the call stack; no reset on contents.
// Write lands on the rising edge; read is asynchronous (zero latency).
// No backpressure. Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module stack_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // raddr may point past DEPTH-1 when the stack is empty; the caller masks it.
  assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// Return-PC LIFO for call/ret with status, replace, sticky errors and high-water.
// top is a combinational read of registered state; push/pop take effect on the next edge.
// No backpressure: push when full / pop when empty are dropped and flagged.
// Ports: clk, reset (async active-high), bus (call_stack_if.slave).
module call_stack
  import limb_pkg::*;
#(
  parameter int DATA_W = LIMB_PC_W,
  parameter int DEPTH  = 16
) (
  input  logic          clk,
  input  logic          reset,
  call_stack_if.slave   bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CNT_W-1:0]  cnt, cnt_nxt, hw;
  logic              ovf, unf;
  logic              ovf_evt, unf_evt;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [AW-1:0]     raddr;
  logic [DATA_W-1:0] rdata;
  logic              is_empty, is_full;
  stack_op_e         op;

  assign op       = stack_op_e'({bus.push, bus.pop});
  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CNT_W'(DEPTH));

  always_comb begin
    cnt_nxt = cnt;
    we      = 1'b0;
    waddr   = AW'(cnt);
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    case (op)
      STK_PUSH: begin
        if (is_full) begin
          ovf_evt = 1'b1;
        end else begin
          we      = 1'b1;
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STK_POP: begin
        if (is_empty) begin
          unf_evt = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      STK_REPLACE: begin
        we = 1'b1;
        if (is_empty) begin
          // Nothing to replace: degrade to a push into slot 0, but flag the pop half.
          cnt_nxt = CNT_W'(1);
          unf_evt = 1'b1;
        end else begin
          waddr = AW'(cnt - CNT_W'(1));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      hw  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      hw  <= CNT_W'(max_cnt(9'(hw), 9'(cnt_nxt)));
      // A new error in the same cycle as clear_err wins.
      ovf <= ovf_evt | (ovf & ~bus.clear_err);
      unf <= unf_evt | (unf & ~bus.clear_err);
    end
  end

  assign raddr = AW'(cnt - CNT_W'(1));

  stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.data_in),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign bus.top        = is_empty ? '0 : rdata;
  assign bus.empty      = is_empty;
  assign bus.full       = is_full;
  assign bus.count      = cnt;
  assign bus.high_water = hw;
  assign bus.overflow   = ovf;
  assign bus.underflow  = unf;

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack with DEPTH=4, DATA_W=8.
// Inputs change 1ns after the rising edge; outputs sampled before the next edge.
// Every comparison goes through check().
module tb_call_stack;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  call_stack_if #(.DATA_W(8), .DEPTH(4)) bus ();

  call_stack #(.DATA_W(8), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Apply one cycle of stimulus, then return 1ns after the edge with inputs idle.
  task automatic do_op(input logic p, input logic q, input logic [7:0] d, input logic clr);
    bus.push      = p;
    bus.pop       = q;
    bus.data_in   = d;
    bus.clear_err = clr;
    @(posedge clk);
    #1;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.data_in   = 8'h00;
    bus.clear_err = 1'b0;
  endtask

  task automatic check_state(input string tag, input int c, input int t, input int hwv,
                             input int o, input int u);
    check({tag, ".count"},      int'(bus.count),      c);
    check({tag, ".top"},        int'(bus.top),        t);
    check({tag, ".empty"},      int'(bus.empty),      (c == 0) ? 1 : 0);
    check({tag, ".full"},       int'(bus.full),       (c == 4) ? 1 : 0);
    check({tag, ".high_water"}, int'(bus.high_water), hwv);
    check({tag, ".overflow"},   int'(bus.overflow),   o);
    check({tag, ".underflow"},  int'(bus.underflow),  u);
  endtask

  logic [7:0] pop_exp [4];

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.data_in   = 8'h00;
    bus.clear_err = 1'b0;
    pop_exp[0] = 8'h44; pop_exp[1] = 8'h33; pop_exp[2] = 8'h22; pop_exp[3] = 8'h11;

    #12;
    check_state("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: three pushes
    do_op(1, 0, 8'h11, 0);
    do_op(1, 0, 8'h22, 0);
    do_op(1, 0, 8'h33, 0);
    check_state("push3", 3, 'h33, 3, 0, 0);

    // 2: fill, then overflow, then clear
    do_op(1, 0, 8'h44, 0);
    check_state("fill", 4, 'h44, 4, 0, 0);
    do_op(1, 0, 8'h55, 0);
    check_state("ovf", 4, 'h44, 4, 1, 0);
    do_op(0, 0, 8'h00, 1);
    check_state("clr_ovf", 4, 'h44, 4, 0, 0);

    // 3: pop from full; popped value visible on top during the pop cycle
    for (int i = 0; i < 4; i++) begin
      bus.pop = 1'b1;
      #1;
      check($sformatf("pop%0d.top", i), int'(bus.top), int'(pop_exp[i]));
      @(posedge clk);
      #1;
      bus.pop = 1'b0;
    end
    check_state("drained", 0, 0, 4, 0, 0);
    do_op(0, 1, 8'h00, 0);
    check_state("unf", 0, 0, 4, 0, 1);

    // 4: replace on non-empty, then on empty
    do_op(0, 0, 8'h00, 1);
    do_op(1, 0, 8'h11, 0);
    do_op(1, 0, 8'h22, 0);
    check_state("two", 2, 'h22, 4, 0, 0);
    do_op(1, 1, 8'hAA, 0);
    check_state("repl", 2, 'hAA, 4, 0, 0);
    do_op(0, 1, 8'h00, 0);
    check_state("below", 1, 'h11, 4, 0, 0);
    do_op(0, 1, 8'h00, 0);
    do_op(1, 1, 8'h5A, 0);
    check_state("repl_empty", 1, 'h5A, 4, 0, 1);

    // 5: clear_err loses to a simultaneous new underflow
    do_op(0, 1, 8'h00, 0);
    check_state("to_empty", 0, 0, 4, 0, 1);
    do_op(0, 1, 8'h00, 1);
    check_state("clr_vs_unf", 0, 0, 4, 0, 1);
    do_op(0, 0, 8'h00, 1);
    check_state("clr_unf", 0, 0, 4, 0, 0);

    // 6: async reset mid-cycle
    do_op(1, 0, 8'h01, 0);
    do_op(1, 0, 8'h02, 0);
    do_op(1, 0, 8'h03, 0);
    do_op(1, 0, 8'h04, 0);
    do_op(1, 0, 8'h05, 0);
    do_op(0, 1, 8'h00, 0);
    check_state("pre_rst", 3, 'h03, 4, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    check_state("async_rst", 0, 0, 0, 0, 0);
    reset = 1'b0;
    do_op(1, 0, 8'h7E, 0);
    check_state("post_rst", 1, 'h7E, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
